// File: rtl/fifo_rd_axis.sv
`default_nettype none
//==============================================================================
// Module   : fifo_rd_axis
// Purpose  : Read-side consumer of an async FIFO. It pops FIFO words and
//            presents them as an AXI4-Stream master with full backpressure.
//            Beats are grouped into packets of PKT_LEN, where tlast marks the
//            final beat. A 32-bit count of completed packets is kept.
//
// Parameters
//   DBITS      data width; matches the FIFO data width
//   SHOWAHEAD  1: fifo_rd_data is the head word while !fifo_empty
//              0: fifo_rd_data is valid one cycle after fifo_rd_en
//   PKT_LEN    beats per packet, 1..65535
//
// Ports
//   clk            in   read-side clock (FIFO read clock)
//   rst_n          in   asynchronous active-low reset, released synchronously
//   en             in   1: fetch from the FIFO; 0: stop new reads and drain
//   fifo_empty     in   FIFO empty flag
//   fifo_rd_en     out  FIFO read enable
//   fifo_rd_data   in   FIFO read data
//   m_axis_tvalid  out  stream valid
//   m_axis_tready  in   stream ready
//   m_axis_tdata   out  stream data
//   m_axis_tlast   out  last beat of a packet
//   pkt_cnt        out  completed packets, wraps at 2^32
//
// Revision : 1.0  initial release
//==============================================================================
module fifo_rd_axis #(
    parameter int DBITS     = 16,
    parameter int SHOWAHEAD = 1,
    parameter int PKT_LEN   = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [DBITS-1:0] fifo_rd_data,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic [DBITS-1:0] m_axis_tdata,
    output logic             m_axis_tlast,
    output logic [31:0]      pkt_cnt
);

    localparam int         c_DEPTH     = 4;
    localparam logic [2:0] c_RD_LIMIT  = 3'd3;
    localparam logic [15:0] c_BEAT_LAST = 16'(PKT_LEN - 1);

    // Output buffer and bookkeeping
    logic [DBITS-1:0] r_buf [c_DEPTH];
    logic [1:0]       r_wr_ptr;
    logic [1:0]       r_rd_ptr;
    logic [2:0]       r_count;
    logic             r_inflight;
    logic [15:0]      r_beat;
    logic [31:0]      r_pkt_cnt;

    logic             w_rd_en;
    logic             w_push;
    logic             w_pop;
    logic             w_beat_last;
    logic [2:0]       w_pending;

    // Words already committed to the buffer: stored ones plus the one whose
    // data is still on its way from a non-showahead FIFO.
    assign w_pending = r_count + {2'b00, r_inflight};

    // Read decision depends only on registered state, en and fifo_empty, so
    // there is no combinational path from tready to the FIFO. Limiting the
    // commitment to 3 words leaves room for a read in flight while the
    // buffer stays within its 4 entries. rst_n keeps the read enable low
    // for the whole reset period.
    assign w_rd_en    = rst_n & en & ~fifo_empty & (w_pending < c_RD_LIMIT);
    assign fifo_rd_en = w_rd_en;

    // Capture point: a showahead FIFO presents the word during the read
    // cycle itself; otherwise the word arrives in the following cycle.
    generate
        if (SHOWAHEAD != 0) begin : g_showahead
            assign w_push = w_rd_en;
        end else begin : g_registered
            assign w_push = r_inflight;
        end
    endgenerate

    assign m_axis_tvalid = (r_count != 3'd0);
    assign m_axis_tdata  = r_buf[r_rd_ptr];
    assign w_pop         = m_axis_tvalid & m_axis_tready;
    assign w_beat_last   = (r_beat == c_BEAT_LAST);
    assign m_axis_tlast  = m_axis_tvalid & w_beat_last;
    assign pkt_cnt       = r_pkt_cnt;

    // In-flight marker for the non-showahead FIFO; stays 0 otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= (SHOWAHEAD == 0) ? w_rd_en : 1'b0;
        end
    end

    // Buffer write side
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < c_DEPTH; k++) begin
                r_buf[k] <= '0;
            end
            r_wr_ptr <= 2'd0;
        end else if (w_push) begin
            r_buf[r_wr_ptr] <= fifo_rd_data;
            r_wr_ptr        <= r_wr_ptr + 2'd1;
        end
    end

    // Buffer read side
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr <= 2'd0;
        end else if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 2'd1;
        end
    end

    // Occupancy: a push and a pop in the same cycle cancel out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 3'd0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + 3'd1;
        end else if (!w_push && w_pop) begin
            r_count <= r_count - 3'd1;
        end
    end

    // Packetizer: the beat position survives en deassertion, so a paused
    // packet resumes where it stopped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat    <= 16'd0;
            r_pkt_cnt <= 32'd0;
        end else if (w_pop) begin
            if (w_beat_last) begin
                r_beat    <= 16'd0;
                r_pkt_cnt <= r_pkt_cnt + 32'd1;
            end else begin
                r_beat    <= r_beat + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_axis.sv
`default_nettype none
//==============================================================================
// Module   : tb_fifo_rd_axis
// Purpose  : Self-checking bench for fifo_rd_axis. Four instances, one per
//            configuration (showahead/registered FIFO, PKT_LEN 256/1/5), each
//            fed by its own FIFO model and compared against a reference built
//            from word queues and beat arithmetic.
// Revision : 1.0  initial release
//==============================================================================
module tb_fifo_rd_axis;

    localparam int NI = 4;
    localparam int DW = 16;

    function automatic int sa_of(input int k);
        return (k % 2 == 0) ? 1 : 0;
    endfunction

    function automatic int pl_of(input int k);
        case (k)
            0, 1:    return 256;
            2:       return 1;
            default: return 5;
        endcase
    endfunction

    logic clk    = 1'b0;
    logic rst_n  = 1'b1;
    logic en     = 1'b0;
    logic tready = 1'b0;
    int   load_total = 0;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    wire            tvalid_w [NI];
    wire            tlast_w  [NI];
    wire            rden_w   [NI];
    wire [DW-1:0]   tdata_w  [NI];
    wire [31:0]     pkt_w    [NI];
    wire [31:0]     rdtot_w  [NI];
    wire            idle_w   [NI];

    for (genvar gi = 0; gi < NI; gi++) begin : g_inst
        localparam int SA = sa_of(gi);
        localparam int PL = pl_of(gi);

        logic          fifo_empty   = 1'b1;
        logic [DW-1:0] fifo_rd_data = '0;
        logic          rd_en;
        logic          tvalid;
        logic          tlast;
        logic [DW-1:0] tdata;
        logic [31:0]   pkt_cnt;

        logic [DW-1:0] fq [$];   // FIFO contents not yet read
        logic [DW-1:0] eq [$];   // words read from the FIFO, not yet delivered
        int  loaded    = 0;
        int  next_word = 1;
        int  infl      = 0;
        int  beat      = 0;
        int  pkts      = 0;
        int  rd_total  = 0;
        bit  idle      = 1'b1;
        bit  hs_s      = 1'b0;
        bit  rd_s      = 1'b0;
        bit  stall     = 1'b0;
        logic [DW-1:0] stall_data = '0;
        logic          stall_last = 1'b0;

        fifo_rd_axis #(
            .DBITS     (DW),
            .SHOWAHEAD (SA),
            .PKT_LEN   (PL)
        ) u_dut (
            .clk           (clk),
            .rst_n         (rst_n),
            .en            (en),
            .fifo_empty    (fifo_empty),
            .fifo_rd_en    (rd_en),
            .fifo_rd_data  (fifo_rd_data),
            .m_axis_tvalid (tvalid),
            .m_axis_tready (tready),
            .m_axis_tdata  (tdata),
            .m_axis_tlast  (tlast),
            .pkt_cnt       (pkt_cnt)
        );

        assign tvalid_w[gi] = tvalid;
        assign tlast_w[gi]  = tlast;
        assign rden_w[gi]   = rd_en;
        assign tdata_w[gi]  = tdata;
        assign pkt_w[gi]    = pkt_cnt;
        assign rdtot_w[gi]  = rd_total;
        assign idle_w[gi]   = idle;

        // Checks on the falling edge, when everything is stable
        always @(negedge clk) begin : b_chk
            int occ;
            if (!rst_n) begin
                check_val($sformatf("i%0d rst tvalid", gi), 32'(tvalid), 32'd0);
                check_val($sformatf("i%0d rst tdata", gi), 32'(tdata), 32'd0);
                check_val($sformatf("i%0d rst tlast", gi), 32'(tlast), 32'd0);
                check_val($sformatf("i%0d rst pkt_cnt", gi), pkt_cnt, 32'd0);
                check_val($sformatf("i%0d rst rd_en", gi), 32'(rd_en), 32'd0);
                hs_s  = 1'b0;
                rd_s  = 1'b0;
                stall = 1'b0;
            end else begin
                occ = eq.size() - infl;
                // At most 3 words may be outstanding between FIFO and sink
                check_val($sformatf("i%0d rd_en", gi), 32'(rd_en),
                          32'(en && !fifo_empty && (eq.size() < 3)));
                check_val($sformatf("i%0d tvalid", gi), 32'(tvalid), 32'(occ > 0));
                if (tvalid && occ > 0) begin
                    check_val($sformatf("i%0d tdata", gi), 32'(tdata), 32'(eq[0]));
                    check_val($sformatf("i%0d tlast", gi), 32'(tlast), 32'(beat == PL - 1));
                end
                if (stall) begin
                    check_val($sformatf("i%0d stall tdata", gi), 32'(tdata), 32'(stall_data));
                    check_val($sformatf("i%0d stall tlast", gi), 32'(tlast), 32'(stall_last));
                end
                check_val($sformatf("i%0d pkt_cnt", gi), pkt_cnt, 32'(pkts));
                if (rd_en) rd_total++;
                hs_s       = tvalid & tready;
                rd_s       = rd_en;
                stall      = tvalid & ~tready;
                stall_data = tdata;
                stall_last = tlast;
            end
        end

        // FIFO model and reference state update
        always @(posedge clk or negedge rst_n) begin : b_mdl
            logic [DW-1:0] w;
            if (!rst_n) begin
                eq.delete();
                infl = 0;
                beat = 0;
                pkts = 0;
            end else begin
                if (hs_s && eq.size() > 0) begin
                    void'(eq.pop_front());
                    if (beat == PL - 1) begin
                        beat = 0;
                        pkts++;
                    end else begin
                        beat++;
                    end
                end
                infl = 0;
                if (rd_s && fq.size() > 0) begin
                    w = fq.pop_front();
                    eq.push_back(w);
                    if (SA == 0) begin
                        fifo_rd_data <= w;
                        infl = 1;
                    end
                end
            end
            while (loaded < load_total) begin
                fq.push_back(DW'(next_word));
                next_word++;
                loaded++;
            end
            fifo_empty <= (fq.size() == 0);
            if (SA != 0) fifo_rd_data <= (fq.size() > 0) ? fq[0] : '0;
            idle = (fq.size() == 0) && (eq.size() == 0);
        end
    end

    // Advance n clocks and land 1 time unit after the rising edge
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic bit all_idle();
        for (int k = 0; k < NI; k++) begin
            if (!idle_w[k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drain(input bit rnd_ready, input int budget);
        int n;
        n = 0;
        step(2);
        while (!all_idle() && n < budget) begin
            tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            step(1);
            n++;
        end
        check_val("drain done", 32'(all_idle()), 32'd1);
        tready = 1'b1;
        step(3);
    endtask

    initial begin : b_main
        int base [NI];
        #1 rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;

        // 1000 words, tready high: full packets for every configuration
        en = 1'b1;
        tready = 1'b1;
        load_total += 1000;
        drain(1'b0, 3000);
        for (int k = 0; k < NI; k++) begin
            check_val($sformatf("i%0d pkts after 1000", k), pkt_w[k], 32'(1000 / pl_of(k)));
        end

        // 5000 words with random backpressure
        load_total += 5000;
        drain(1'b1, 40000);

        // Sink blocked: only three reads may be issued
        tready = 1'b0;
        for (int k = 0; k < NI; k++) base[k] = int'(rdtot_w[k]);
        load_total += 20;
        step(15);
        for (int k = 0; k < NI; k++) begin
            check_val($sformatf("i%0d reads while blocked", k), rdtot_w[k] - 32'(base[k]), 32'd3);
        end
        tready = 1'b1;
        drain(1'b0, 200);

        // Reset mid-packet, then pause en while the buffer drains
        load_total += 300;
        step(94);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NI; k++) begin
            check_val($sformatf("i%0d async tvalid", k), 32'(tvalid_w[k]), 32'd0);
            check_val($sformatf("i%0d async tlast", k), 32'(tlast_w[k]), 32'd0);
            check_val($sformatf("i%0d async pkt_cnt", k), pkt_w[k], 32'd0);
            check_val($sformatf("i%0d async rd_en", k), 32'(rden_w[k]), 32'd0);
        end
        step(3);
        rst_n = 1'b1;
        step(4);
        en = 1'b0;
        for (int c = 0; c < 20; c++) begin
            tready = 1'($urandom_range(0, 1));
            step(1);
        end
        en = 1'b1;
        drain(1'b0, 1000);

        // Random en, tready and FIFO fill rate
        for (int c = 0; c < 3000; c++) begin
            en     = ($urandom_range(0, 7) != 0);
            tready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 99) < 45) load_total += 1;
            step(1);
        end
        en = 1'b1;
        drain(1'b0, 3000);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
